weight_index_sequencer: RTL and testbench
=========================================

# weight_index_sequencer

Drives the `index` input of a `weight_buffer_*` ROM bank, which has a fixed 2-cycle read latency, and produces valid/first/last tags aligned cycle-for-cycle with the buffer's `q_*` outputs. It sweeps all rows of the buffer one or more times per `start` command, honours a downstream enable by inserting bubbles, and signals completion. It sits between the layer controller and the weight buffer; the tags travel alongside `q_*` into the MAC array.

## Interface
Parameters:
- `INDEX_WIDTH`, 6, width of the `index`/`row_tag` buses.
- `NUM_ROWS`, 64, rows per pass; index sweeps 0..NUM_ROWS-1 (2 ≤ NUM_ROWS ≤ 2^INDEX_WIDTH).
- `LATENCY`, 2, cycles from `index` presented to matching `q_*` valid at the buffer output (≥1).
- `PASS_WIDTH`, 8, width of `passes`.

Ports:
- `clk`  input  1  single clock; everything is on the rising edge.
- `reset`  input  1  reset, synchronous and active-low.
- `start`  input  1  command pulse; sampled only in IDLE.
- `passes`  input  PASS_WIDTH  number of full sweeps; latched on an accepted `start`; 0 is treated as 1.
- `en`  input  1  downstream enable; 0 in RUN issues a bubble.
- `index`  output  INDEX_WIDTH  registered row address to the weight buffer.
- `data_valid`  output  1  `q_*` this cycle carry an issued row.
- `data_first`  output  1  with `data_valid`: row 0 of pass 0.
- `data_last`  output  1  with `data_valid`: final row of final pass.
- `row_tag`  output  INDEX_WIDTH  row number of the current `q_*` data.
- `busy`  output  1  state is RUN or DRAIN.
- `done`  output  1  one-cycle pulse after the `data_last` cycle.

## Operation
- States:
  - IDLE: `index` = 0 and no issue.
  - RUN: issues rows.
  - DRAIN: waits LATENCY cycles for in-flight data.
- IDLE→RUN on `start`=1. Latch `passes` (0→1), clear the pass counter, `index` = 0.
- RUN issue rule: an issue occurs in a cycle iff state=RUN and `en`=1. The issued row is the current `index`.
- After an issue:
  - If `index` < NUM_ROWS-1, `index` increments.
  - Otherwise `index` wraps to 0 and the pass counter increments.
  - If the pass counter reaches the latched pass count (the final row of the final pass was issued), go to DRAIN.
- With `en`=0 in RUN, `index`, the pass counter and the state hold, and a bubble is issued.
- DRAIN: a counter runs for LATENCY cycles, then the block goes to IDLE and asserts `done` for that one IDLE cycle.
- Tag pipeline: LATENCY-deep shift registers for {issue, first, last, row}.
  - They shift every cycle regardless of `en`, because the buffer is free-running.
  - Outputs are the last stage. `first` = issue of row 0 in pass 0; `last` = final issue.
- `start` in RUN or DRAIN is ignored. `start` in the `done` cycle is accepted; RUN begins the next cycle.
- `reset`=0 (any state, mid-sweep included) on the next edge:
  - state IDLE;
  - `index`, counters and the whole tag pipeline cleared;
  - all outputs 0.
  - In-flight tags are discarded; no `done` is produced.
- Pass counter is PASS_WIDTH wide; 2^PASS_WIDTH-1 passes must work without overflow.

## Timing
- Reset value of every output is 0.
- `start` sampled at edge of cycle 0:
  - RUN from cycle 1, `index` = 0 in cycle 1.
  - `busy` = 1 from cycle 1.
- Issue at cycle t ⇒ `data_valid`/tags at cycle t+LATENCY, with `row_tag` = issued index.
- No stalls, P passes: issues at cycles 1..P·NUM_ROWS.
  - DRAIN occupies the next LATENCY cycles.
  - `data_last` appears at cycle P·NUM_ROWS+LATENCY.
  - `done` = 1 and `busy` = 0 at cycle P·NUM_ROWS+LATENCY+1.
- Each `en`=0 cycle in RUN delays all later events by one cycle and produces exactly one `data_valid`=0 cycle, LATENCY cycles later.
- `busy` and `done` are never high in the same cycle.

## Test plan
- Reset, `start`=1 at cycle 0, `passes`=1, `en`=1, defaults:
  - `index` 0..63 on cycles 1..64;
  - `data_valid` cycles 3..66, `row_tag` 0..63;
  - `data_first` at 3, `data_last` at 66, `done` at 67, `busy` low at 67.
- `passes`=0 → identical to `passes`=1.
- `passes`=3 → 192 valid cycles; `row_tag` wraps 63→0 twice; exactly one `data_first` (cycle 3) and one `data_last` (cycle 194); `done` at 195.
- `en`=0 on cycles 5 and 6 (indices 4 and 5 pending):
  - `index` holds 4 through cycle 6;
  - `data_valid`=0 at cycles 7 and 8;
  - `row_tag` 4 appears at cycle 9;
  - `done` at 69.
- `start` pulsed during RUN at cycle 20 → ignored, `done` still at 67. `start` at cycle 67 → `index` = 0 in cycle 68, second `data_first` at 70.
- `reset`=0 at cycle 30 → cycle 31 all outputs 0 and state IDLE; no `data_valid` or `done` afterwards until a new `start`.

Source files
------------

// File: rtl/weight_index_sequencer.sv
`default_nettype none
// weight_index_sequencer: sweeps weight_buffer rows per start command and emits
// valid/first/last/row tags aligned with the buffer's fixed-latency q outputs. Rev 1.0
module weight_index_sequencer #(
   parameter int INDEX_WIDTH = 6,
   parameter int NUM_ROWS    = 64,
   parameter int LATENCY     = 2,
   parameter int PASS_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [PASS_WIDTH-1:0]  passes,
   input  logic                   en,
   output logic [INDEX_WIDTH-1:0] index,
   output logic                   data_valid,
   output logic                   data_first,
   output logic                   data_last,
   output logic [INDEX_WIDTH-1:0] row_tag,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam int                     DRAIN_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [INDEX_WIDTH-1:0] LAST_ROW  = INDEX_WIDTH'(NUM_ROWS - 1);
   localparam logic [DRAIN_W-1:0]     DRAIN_END = DRAIN_W'(LATENCY - 1);

   state_t                  state_q, state_d;
   logic [INDEX_WIDTH-1:0]  index_q, index_d;
   logic [PASS_WIDTH-1:0]   pass_cnt_q, pass_cnt_d;
   logic [PASS_WIDTH-1:0]   passes_q, passes_d;
   logic [DRAIN_W-1:0]      drain_cnt_q, drain_cnt_d;
   logic                    done_q, done_d;
   logic                    issue, issue_first, issue_last;

   logic [LATENCY-1:0]      vld_q, fst_q, lst_q;
   logic [INDEX_WIDTH-1:0]  row_q [LATENCY];

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      pass_cnt_d  = pass_cnt_q;
      passes_d    = passes_q;
      drain_cnt_d = drain_cnt_q;
      done_d      = 1'b0;

      issue       = (state_q == S_RUN) && en;
      issue_first = issue && (index_q == '0) && (pass_cnt_q == '0);
      // Widened compare so a pass count of 2^PASS_WIDTH-1 cannot overflow.
      issue_last  = issue && (index_q == LAST_ROW) &&
                    (({1'b0, pass_cnt_q} + 1'b1) == {1'b0, passes_q});

      case (state_q)
         S_IDLE: begin
            index_d = '0;
            if (start) begin
               state_d    = S_RUN;
               passes_d   = (passes == '0) ? PASS_WIDTH'(1) : passes;
               pass_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (issue) begin
               if (index_q == LAST_ROW) begin
                  index_d    = '0;
                  pass_cnt_d = pass_cnt_q + 1'b1;
               end else begin
                  index_d = index_q + 1'b1;
               end
               if (issue_last) begin
                  state_d     = S_DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         S_DRAIN: begin
            if (drain_cnt_q == DRAIN_END) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         pass_cnt_q  <= '0;
         passes_q    <= '0;
         drain_cnt_q <= '0;
         done_q      <= 1'b0;
         vld_q       <= '0;
         fst_q       <= '0;
         lst_q       <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            row_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         pass_cnt_q  <= pass_cnt_d;
         passes_q    <= passes_d;
         drain_cnt_q <= drain_cnt_d;
         done_q      <= done_d;
         // Tags shift every cycle because the buffer itself never stalls.
         vld_q[0]    <= issue;
         fst_q[0]    <= issue_first;
         lst_q[0]    <= issue_last;
         row_q[0]    <= index_q;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            fst_q[i] <= fst_q[i-1];
            lst_q[i] <= lst_q[i-1];
            row_q[i] <= row_q[i-1];
         end
      end
   end

   assign index      = index_q;
   assign data_valid = vld_q[LATENCY-1];
   assign data_first = fst_q[LATENCY-1];
   assign data_last  = lst_q[LATENCY-1];
   assign row_tag    = row_q[LATENCY-1];
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_index_sequencer.sv
`default_nettype none
// Directed bench for weight_index_sequencer (INDEX_WIDTH=6, NUM_ROWS=64, LATENCY=2).
module tb_weight_index_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] passes;
   logic       en;
   logic [5:0] index;
   logic       data_valid;
   logic       data_first;
   logic       data_last;
   logic [5:0] row_tag;
   logic       busy;
   logic       done;

   int total;
   int bad;

   bit       iv [0:16400];
   bit       fv [0:16400];
   bit       lv [0:16400];
   int       rv [0:16400];

   weight_index_sequencer #(
      .INDEX_WIDTH (6),
      .NUM_ROWS    (64),
      .LATENCY     (2),
      .PASS_WIDTH  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .passes     (passes),
      .en         (en),
      .index      (index),
      .data_valid (data_valid),
      .data_first (data_first),
      .data_last  (data_last),
      .row_tag    (row_tag),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag, input int c);
      chk({tag, ".index"}, c, 32'(index), 0);
      chk({tag, ".valid"}, c, 32'(data_valid), 0);
      chk({tag, ".first"}, c, 32'(data_first), 0);
      chk({tag, ".last"}, c, 32'(data_last), 0);
      chk({tag, ".row_tag"}, c, 32'(row_tag), 0);
      chk({tag, ".busy"}, c, 32'(busy), 0);
      chk({tag, ".done"}, c, 32'(done), 0);
   endtask

   // Caller is in cycle 0 with start/passes already driven; returns in the done cycle.
   // s1/s2: cycles with en=0 (0 = none); sp: cycle to pulse start during the run.
   task automatic sweep(input string tag, input int np, input int s1, input int s2, input int sp);
      int  n_iss;
      int  n_stall;
      int  endc;
      int  k;
      bit  ev;
      n_iss   = np * 64;
      n_stall = ((s1 != 0) ? 1 : 0) + ((s2 != 0) ? 1 : 0);
      endc    = n_iss + n_stall;
      k       = 0;
      cyc();
      for (int c = 1; c <= endc + 3; c++) begin
         start = (c == sp);
         en    = !((c == s1) || (c == s2));
         if (c <= endc) begin
            chk({tag, ".index"}, c, 32'(index), 32'(k % 64));
            iv[c] = en;
            rv[c] = k % 64;
            fv[c] = en && (k == 0);
            lv[c] = en && (k == n_iss - 1);
            if (en) k++;
         end else begin
            chk({tag, ".index"}, c, 32'(index), 0);
         end
         chk({tag, ".busy"}, c, 32'(busy), 32'(c <= endc + 2));
         chk({tag, ".done"}, c, 32'(done), 32'(c == endc + 3));
         ev = (c >= 3 && c - 2 <= endc) ? iv[c-2] : 1'b0;
         chk({tag, ".valid"}, c, 32'(data_valid), 32'(ev));
         chk({tag, ".first"}, c, 32'(data_first), ev ? 32'(fv[c-2]) : 0);
         chk({tag, ".last"}, c, 32'(data_last), ev ? 32'(lv[c-2]) : 0);
         if (ev) chk({tag, ".row_tag"}, c, 32'(row_tag), 32'(rv[c-2]));
         if (c < endc + 3) cyc();
      end
      start = 1'b0;
      en    = 1'b1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      reset  = 1'b0;
      start  = 1'b0;
      en     = 1'b1;
      passes = 8'd0;

      repeat (3) cyc();
      chk_zero("reset", 0);
      reset = 1'b1;
      cyc();
      cyc();
      chk_zero("idle", 0);

      // Single pass, then passes=0 which must behave as one pass.
      start = 1'b1; passes = 8'd1;
      sweep("p1", 1, 0, 0, 0);
      cyc();
      start = 1'b1; passes = 8'd0;
      sweep("p0", 1, 0, 0, 0);
      cyc();

      start = 1'b1; passes = 8'd3;
      sweep("p3", 3, 0, 0, 0);
      cyc();

      // Bubbles on cycles 5 and 6: index holds 4, gap at 7/8, done at 69.
      start = 1'b1; passes = 8'd1;
      sweep("stall", 1, 5, 6, 0);
      cyc();

      // Start during RUN ignored; start in the done cycle chains a new sweep.
      start = 1'b1; passes = 8'd1;
      sweep("ign", 1, 0, 0, 20);
      start = 1'b1; passes = 8'd1;
      sweep("chain", 1, 0, 0, 0);
      cyc();

      // Mid-sweep reset at cycle 30.
      start = 1'b1; passes = 8'd1;
      cyc();
      start = 1'b0;
      for (int c = 1; c < 30; c++) cyc();
      chk("rst.busy_before", 30, 32'(busy), 1);
      chk("rst.valid_before", 30, 32'(data_valid), 1);
      chk("rst.row_before", 30, 32'(row_tag), 27);
      reset = 1'b0;
      cyc();
      chk_zero("rst", 31);
      reset = 1'b1;
      for (int c = 32; c < 45; c++) begin
         cyc();
         chk("rst.valid_after", c, 32'(data_valid), 0);
         chk("rst.done_after", c, 32'(done), 0);
         chk("rst.busy_after", c, 32'(busy), 0);
      end

      // Maximum pass count must not overflow the pass counter.
      start = 1'b1; passes = 8'd255;
      sweep("p255", 255, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
